// File: rtl/flag_branch_if.sv
// Branch request bus between decode/execute and flag_branch_unit.
// valid/ready: a request transfers on a rising edge where br_valid & br_ready are both 1.
interface flag_branch_if #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9
);
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_ccc;
  logic              br_is_reg;
  logic [ADDR_W-1:0] br_pc;
  logic [IMM_W-1:0]  br_imm;
  logic [ADDR_W-1:0] br_reg;

  modport master (
    output br_valid, br_ccc, br_is_reg, br_pc, br_imm, br_reg,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_ccc, br_is_reg, br_pc, br_imm, br_reg,
    output br_ready
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Z/V/N flag register, conditional branch resolution and registered PC redirect.
// FLAG_BYPASS_EN: resolve a branch that coincides with a flag write using bypassed flags instead of a HOLD cycle.
module flag_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [2:0]        alu_flags,
  input  logic [2:0]        alu_en,
  flag_branch_if.slave      br,
  input  logic              flush,
  output logic              redirect_valid,
  output logic              redirect_taken,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [2:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic              dbg_state
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t            state;
  logic [2:0]        hold_ccc;
  logic              hold_is_reg;
  logic [ADDR_W-1:0] hold_pc;
  logic [IMM_W-1:0]  hold_imm;
  logic [ADDR_W-1:0] hold_reg;

  logic [2:0]        flags_nxt;
  logic [2:0]        run_flags;
  logic              go_hold;
  logic              br_ready_w;
  logic              accept;
  logic              in_hold;
  logic              do_resolve;

  logic [2:0]        res_ccc;
  logic              res_is_reg;
  logic [ADDR_W-1:0] res_pc;
  logic [IMM_W-1:0]  res_imm;
  logic [ADDR_W-1:0] res_reg;
  logic [2:0]        res_flags;
  logic [ADDR_W-1:0] res_fall;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] res_b_tgt;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;

  // flags bit2=Z, bit1=V, bit0=N
  function automatic logic cond_true(input logic [2:0] ccc, input logic [2:0] f);
    case (ccc)
      3'b000:  cond_true = ~f[2];
      3'b001:  cond_true = f[2];
      3'b010:  cond_true = ~f[2] & ~f[0];
      3'b011:  cond_true = f[0];
      3'b100:  cond_true = f[2] | ~f[0];
      3'b101:  cond_true = f[0] | f[2];
      3'b110:  cond_true = f[1];
      default: cond_true = 1'b1;
    endcase
  endfunction

  assign flags_nxt = alu_valid ? ((alu_en & alu_flags) | (~alu_en & flags_q)) : flags_q;

`ifdef FLAG_BYPASS_EN
  assign go_hold   = 1'b0;
  assign run_flags = flags_nxt;
`else
  logic flag_wr;
  assign flag_wr   = alu_valid & (|alu_en);
  assign go_hold   = flag_wr;
  assign run_flags = flags_q;
`endif

  assign in_hold     = (state == HOLD);
  assign br_ready_w  = ~in_hold & ~flush;
  assign br.br_ready = br_ready_w;
  assign accept      = br.br_valid & br_ready_w;
  assign do_resolve  = in_hold ? ~flush : (accept & ~go_hold);
  assign dbg_state   = state;

  // In HOLD the captured request is resolved against the flags written last cycle.
  assign res_ccc    = in_hold ? hold_ccc    : br.br_ccc;
  assign res_is_reg = in_hold ? hold_is_reg : br.br_is_reg;
  assign res_pc     = in_hold ? hold_pc     : br.br_pc;
  assign res_imm    = in_hold ? hold_imm    : br.br_imm;
  assign res_reg    = in_hold ? hold_reg    : br.br_reg;
  assign res_flags  = in_hold ? flags_q     : run_flags;

  assign res_fall   = res_pc + ADDR_W'(2);
  assign imm_ext    = {{(ADDR_W-IMM_W){res_imm[IMM_W-1]}}, res_imm};
  assign res_b_tgt  = res_fall + {imm_ext[ADDR_W-2:0], 1'b0};
  assign res_taken  = cond_true(res_ccc, res_flags);
  assign res_target = !res_taken ? res_fall : (res_is_reg ? res_reg : res_b_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      flags_q        <= 3'b000;
      redirect_valid <= 1'b0;
      redirect_taken <= 1'b0;
      redirect_pc    <= '0;
      taken_cnt      <= '0;
      hold_ccc       <= 3'b000;
      hold_is_reg    <= 1'b0;
      hold_pc        <= '0;
      hold_imm       <= '0;
      hold_reg       <= '0;
    end else begin
      flags_q        <= flags_nxt;
      redirect_valid <= do_resolve;
      if (do_resolve) begin
        redirect_taken <= res_taken;
        redirect_pc    <= res_target;
        if (res_taken && (taken_cnt != {CNT_W{1'b1}}))
          taken_cnt <= taken_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (accept && go_hold) begin
            hold_ccc    <= br.br_ccc;
            hold_is_reg <= br.br_is_reg;
            hold_pc     <= br.br_pc;
            hold_imm    <= br.br_imm;
            hold_reg    <= br.br_reg;
            state       <= HOLD;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit (CNT_W=4 so counter saturation is reachable).
module tb_flag_branch_unit;
  localparam int ADDR_W = 16;
  localparam int IMM_W  = 9;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic [2:0]        alu_flags;
  logic [2:0]        alu_en;
  logic              flush;
  logic              redirect_valid;
  logic              redirect_taken;
  logic [ADDR_W-1:0] redirect_pc;
  logic [2:0]        flags_q;
  logic [CNT_W-1:0]  taken_cnt;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [7:0] tbl;

  flag_branch_if #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) bif ();

  flag_branch_unit #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_flags      (alu_flags),
    .alu_en         (alu_en),
    .br             (bif.slave),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_taken (redirect_taken),
    .redirect_pc    (redirect_pc),
    .flags_q        (flags_q),
    .taken_cnt      (taken_cnt),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  // driver tasks
  task automatic drive_br(input logic v, input logic [2:0] ccc, input logic is_reg,
                          input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] rg);
    bif.br_valid  = v;
    bif.br_ccc    = ccc;
    bif.br_is_reg = is_reg;
    bif.br_pc     = pc;
    bif.br_imm    = imm;
    bif.br_reg    = rg;
  endtask

  task automatic drive_alu(input logic v, input logic [2:0] f, input logic [2:0] en);
    alu_valid = v;
    alu_flags = f;
    alu_en    = en;
  endtask

  task automatic check_redirect(input string tag, input logic taken, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(redirect_valid), 32'(1));
    check({tag, "_taken"}, 32'(redirect_taken), 32'(taken));
    check({tag, "_pc"},    32'(redirect_pc),    32'(pc));
    check({tag, "_cnt"},   32'(taken_cnt),      32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive_alu(1'b0, 3'b000, 3'b000);
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // reset state
    check("rst_flags", 32'(flags_q), 32'(0));
    check("rst_rv", 32'(redirect_valid), 32'(0));
    check("rst_cnt", 32'(taken_cnt), 32'(0));
    check("rst_ready", 32'(bif.br_ready), 32'(1));
    check("rst_state", 32'(dbg_state), 32'(0));

    // flag register partial writes
    drive_alu(1'b1, 3'b111, 3'b100);
    tick();
    check("flag_z", 32'(flags_q), 32'(3'b100));
    drive_alu(1'b1, 3'b000, 3'b011);
    tick();
    check("flag_vn0", 32'(flags_q), 32'(3'b100));
    drive_alu(1'b0, 3'b011, 3'b111);
    tick();
    check("flag_nowr", 32'(flags_q), 32'(3'b100));

    // B EQ taken, then NE not taken back-to-back
    drive_br(1'b1, 3'b001, 1'b0, 16'h0010, 9'h1FE, 16'h0);
    check("b_ready", 32'(bif.br_ready), 32'(1));
    tick();
    bump();
    check_redirect("b_eq", 1'b1, 16'h000E);
    drive_br(1'b1, 3'b000, 1'b0, 16'h0010, 9'h1FE, 16'h0);
    tick();
    check_redirect("b_ne", 1'b0, 16'h0012);
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);
    tick();
    check("rv_pulse", 32'(redirect_valid), 32'(0));
    check("pc_hold", 32'(redirect_pc), 32'(16'h0012));

    // BR always, B wrap
    drive_br(1'b1, 3'b111, 1'b1, 16'hFFFE, 9'h0, 16'hBEEF);
    tick();
    bump();
    check_redirect("br_al", 1'b1, 16'hBEEF);
    drive_br(1'b1, 3'b111, 1'b0, 16'hFFFE, 9'h000, 16'h0);
    tick();
    bump();
    check_redirect("b_wrap", 1'b1, 16'h0000);

    // every condition with Z=1,V=0,N=0
    tbl = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      drive_br(1'b1, 3'(i), 1'b0, 16'h0100, 9'h004, 16'h0);
      tick();
      if (tbl[i]) bump();
      check_redirect($sformatf("cc100_%0d", i), tbl[i], tbl[i] ? 16'h010A : 16'h0102);
    end
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);

    // every condition with Z=0,V=1,N=1
    drive_alu(1'b1, 3'b011, 3'b111);
    tick();
    drive_alu(1'b0, 3'b000, 3'b000);
    check("flag_011", 32'(flags_q), 32'(3'b011));
    tbl = 8'b1110_1001;
    for (int i = 0; i < 8; i++) begin
      drive_br(1'b1, 3'(i), 1'b0, 16'h0200, 9'h1F0, 16'h0);
      tick();
      if (tbl[i]) bump();
      check_redirect($sformatf("cc011_%0d", i), tbl[i], tbl[i] ? 16'h01E2 : 16'h0202);
    end
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);

    // branch coinciding with a flag write
    drive_alu(1'b1, 3'b000, 3'b111);
    tick();
    check("flag_clr", 32'(flags_q), 32'(0));
    drive_alu(1'b1, 3'b100, 3'b100);
    drive_br(1'b1, 3'b001, 1'b0, 16'h0010, 9'h1FE, 16'h0);
    tick();
    drive_alu(1'b0, 3'b000, 3'b000);
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);
    check("il_flags", 32'(flags_q), 32'(3'b100));
`ifdef FLAG_BYPASS_EN
    bump();
    check_redirect("il_byp", 1'b1, 16'h000E);
    check("il_ready", 32'(bif.br_ready), 32'(1));
`else
    check("il_rv0", 32'(redirect_valid), 32'(0));
    check("il_ready0", 32'(bif.br_ready), 32'(0));
    check("il_state", 32'(dbg_state), 32'(1));
    tick();
    bump();
    check_redirect("il_hold", 1'b1, 16'h000E);
    check("il_ready1", 32'(bif.br_ready), 32'(1));
`endif

    // flush while holding
    drive_alu(1'b1, 3'b000, 3'b111);
    tick();
    drive_alu(1'b1, 3'b100, 3'b100);
    drive_br(1'b1, 3'b001, 1'b0, 16'h0010, 9'h1FE, 16'h0);
    tick();
    drive_alu(1'b0, 3'b000, 3'b000);
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);
    flush = 1'b1;
`ifdef FLAG_BYPASS_EN
    bump();
    check("fl_byp_rv", 32'(redirect_valid), 32'(1));
`endif
    tick();
    flush = 1'b0;
    check("fl_rv0", 32'(redirect_valid), 32'(0));
    check("fl_state", 32'(dbg_state), 32'(0));
    check("fl_cnt", 32'(taken_cnt), 32'(exp_cnt));
    check("fl_flags", 32'(flags_q), 32'(3'b100));

    // flush in RUN blocks acceptance
    flush = 1'b1;
    drive_br(1'b1, 3'b111, 1'b0, 16'h0030, 9'h0, 16'h0);
    #1;
    check("flrun_ready", 32'(bif.br_ready), 32'(0));
    tick();
    check("flrun_rv", 32'(redirect_valid), 32'(0));
    flush = 1'b0;

    // counter saturation
    for (int i = 0; i < 17; i++) begin
      drive_br(1'b1, 3'b111, 1'b0, 16'h0040, 9'h0, 16'h0);
      tick();
      bump();
      check($sformatf("sat_%0d", i), 32'(taken_cnt), 32'(exp_cnt));
    end
    check("sat_final", 32'(taken_cnt), 32'(4'hF));
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);
    tick();

    // asynchronous reset while holding
    drive_alu(1'b1, 3'b010, 3'b010);
    drive_br(1'b1, 3'b110, 1'b0, 16'h0050, 9'h0, 16'h0);
    tick();
    drive_alu(1'b0, 3'b000, 3'b000);
    drive_br(1'b0, 3'b000, 1'b0, 16'h0, 9'h0, 16'h0);
    rst_n = 1'b0;
    #1;
    check("mrst_state", 32'(dbg_state), 32'(0));
    check("mrst_rv", 32'(redirect_valid), 32'(0));
    check("mrst_cnt", 32'(taken_cnt), 32'(0));
    check("mrst_flags", 32'(flags_q), 32'(0));
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("mrst_norv", 32'(redirect_valid), 32'(0));
    check("mrst_ready", 32'(bif.br_ready), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sits directly downstream of the 16-bit execute ALU and consumes its 3-bit ZVN flag vector and per-flag update enables.
- Holds the architectural Z/V/N flag register and resolves conditional branches (PC-relative B and register-indirect BR) against those flags.
- Produces a registered PC redirect to fetch.
- Keeps a saturating taken-branch counter for performance debug.

Parameters:
- ADDR_W, 16, PC and register-target width.
- IMM_W, 9, branch offset width (signed, in halfwords).
- CNT_W, 16, taken-branch counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  execute-stage instruction valid this cycle.
- alu_flags  in  3  ALU flags {Z,V,N}: bit2=Z, bit1=V, bit0=N.
- alu_en  in  3  per-flag write enables, same bit order as alu_flags.
- br_valid  in  1  branch request present.
- br_ready  out  1  branch request accepted when br_valid & br_ready.
- br_ccc  in  3  condition code.
- br_is_reg  in  1  1 = BR (target br_reg), 0 = B (PC-relative).
- br_pc  in  ADDR_W  address of the branch instruction.
- br_imm  in  IMM_W  signed halfword offset.
- br_reg  in  ADDR_W  register target for BR.
- flush  in  1  synchronous kill of any pending or held branch.
- redirect_valid  out  1  one-cycle pulse: branch resolved.
- redirect_taken  out  1  condition true.
- redirect_pc  out  ADDR_W  next PC.
- flags_q  out  3  current flag register {Z,V,N}.
- taken_cnt  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (rst_n=0, async): flags_q=3'b000, redirect_valid=0, redirect_taken=0, redirect_pc=0, taken_cnt=0, state=RUN, br_ready=1 once released.
- Flag register: on posedge, if alu_valid, each bit i with alu_en[i]=1 loads alu_flags[i]; bits with en=0 hold. alu_valid=0 ignores alu_en.
- Conditions (f = flags seen by branch):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- Target computation:
  - fallthrough = br_pc + 2.
  - B taken: fallthrough + (sign_ext(br_imm) << 1), modulo 2^ADDR_W wrap.
  - BR taken: br_reg.
  - Not taken: fallthrough.
- Latency: an accepted request produces redirect_valid=1 on the next rising edge, for exactly one cycle. redirect_* hold their values until the next resolution; redirect_valid returns to 0.
- Back-to-back requests are accepted every cycle in RUN.
- FSM states:
  - RUN: br_ready=1.
    - If br_valid and no flag write this cycle (alu_valid & |alu_en = 0): resolve with flags_q.
    - If br_valid and a flag write coincides: interlock behaviour is per the Optional Feature.
  - HOLD: br_ready=0 for exactly one cycle; the captured request (ccc, is_reg, pc, imm, reg) is resolved with the now-updated flags_q, then return to RUN.
- taken_cnt increments on each taken resolution and saturates at all-ones; it never wraps.
- flush:
  - Asserted in RUN: the same-cycle request is not accepted (br_ready=0).
  - Asserted in HOLD: the held request is dropped; no redirect_valid; go to RUN.
  - Flag writes are unaffected by flush.
- rst_n low mid-HOLD: returns to RUN; the held request is discarded.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: a branch coinciding with a flag write resolves in RUN with the bypassed flags, per bit (en ? alu_flags : flags_q). No HOLD state is ever entered; latency is always 1.
- Undefined: the coinciding branch is captured, the FSM enters HOLD, and the redirect appears 2 cycles after the request.

Test Plan:
- Reset release, no stimulus -> flags_q=000, redirect_valid=0, taken_cnt=0, br_ready=1.
- alu_valid=1, alu_flags=111, alu_en=100; next cycle alu_flags=000, alu_en=011 -> flags_q=100 then 100 (V,N written 0); alu_valid=0 with en=111 -> no change.
- flags_q=100, B ccc=001, br_pc=16'h0010, br_imm=9'h1FE (-2) -> next cycle redirect_valid=1, taken=1, pc=16'h000E, taken_cnt=1; same request with ccc=000 -> taken=0, pc=16'h0012.
- BR ccc=111, br_reg=16'hBEEF, br_pc=16'hFFFE -> redirect_pc=16'hBEEF. B ccc=111, br_pc=16'hFFFE, imm=0 -> redirect_pc=16'h0000 (wrap).
- flags_q=000, same-cycle alu write Z=1 (en=100) with B ccc=001 -> without FLAG_BYPASS_EN: br_ready=0 next cycle, redirect taken 2 cycles later; with it: taken after 1 cycle. Repeat with flush in HOLD -> no redirect.
- Force taken_cnt to all-ones (CNT_W=4 build, 16 taken branches) -> stays 4'hF after a 17th taken branch.
